min_serial: RTL and testbench



---
 rtl/min_serial.sv | 87 ++++++++
 tb/tb_min_serial.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/min_serial.sv
// Streaming argmin: accepts 2**WIDTH unsigned distances in index order and
// presents the index/value of the smallest one on a valid/ready result port.
module min_serial #(
  parameter int WIDTH  = 3,
  parameter int LENGTH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_index,
  output logic [LENGTH-1:0] out_value,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    best_index_q, best_index_d;
  logic [LENGTH-1:0]   best_value_q, best_value_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      best_index_q <= '0;
      best_value_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      best_index_q <= best_index_d;
      best_value_q <= best_value_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    best_index_d = best_index_q;
    best_value_d = best_value_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          // First beat seeds the running minimum; strict compare keeps the lower index on ties.
          if (cnt_q == '0 || in_data < best_value_q) begin
            best_value_d = in_data;
            best_index_d = cnt_q;
          end
          cnt_d = cnt_q + WIDTH'(1);
          if (cnt_q == '1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ACCUM) || (state_q == DONE);
  assign out_index = best_index_q;
  assign out_value = best_value_q;

endmodule

// File: tb/tb_min_serial.sv
// Directed bench for min_serial: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor compares whenever out_valid is high.
module tb_min_serial;

  localparam int WIDTH  = 3;
  localparam int LENGTH = 10;
  localparam int N      = 1 << WIDTH;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [LENGTH-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_index;
  logic [LENGTH-1:0] out_value;
  logic              busy;

  min_serial #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_value (out_value),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  logic [WIDTH+LENGTH-1:0] sb_q[$];
  int vals[N];
  int gaps[N];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the result is offered, compare against the head of
  // the scoreboard; pop when the consumer is accepting it on the coming edge.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        chk("out_index", int'(out_index), int'(sb_q[0][WIDTH+LENGTH-1:LENGTH]));
        chk("out_value", int'(out_value), int'(sb_q[0][LENGTH-1:0]));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Entered at #1 after a posedge with the DUT in IDLE.
  task automatic run_frame(input int exp_i, input int exp_v, input int bp,
                           input bit pulse_accum, input bit pulse_done);
    logic [WIDTH-1:0]  ei;
    logic [LENGTH-1:0] ev;
    ei = exp_i[WIDTH-1:0];
    ev = exp_v[LENGTH-1:0];
    sb_q.push_back({ei, ev});
    chk("idle_in_ready", int'(in_ready), 0);
    chk("idle_out_valid", int'(out_valid), 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_latency_in_ready", int'(in_ready), 1);
    chk("accum_busy", int'(busy), 1);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b0;
      for (int g = 0; g < gaps[i]; g++) begin
        @(posedge clk); #1;
      end
      if (gaps[i] > 0) chk("stall_in_ready", int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = vals[i][LENGTH-1:0];
      start    = pulse_accum && (i == 2);
      @(posedge clk); #1;
      in_valid = 1'b0;
      start    = 1'b0;
      if (i < N - 1) chk("accum_out_valid", int'(out_valid), 0);
    end
    chk("result_latency", int'(out_valid), 1);
    chk("done_in_ready", int'(in_ready), 0);
    chk("done_busy", int'(busy), 1);
    if (pulse_done) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_ignores_start", int'(out_valid), 1);
    end
    for (int b = 0; b < bp; b++) begin
      @(posedge clk); #1;
      chk("backpressure_hold", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_out_valid", int'(out_valid), 0);
    chk("release_busy", int'(busy), 0);
    chk("release_in_ready", int'(in_ready), 0);
  endtask

  task automatic set_no_gaps();
    for (int i = 0; i < N; i++) gaps[i] = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    set_no_gaps();
    #12;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_index", int'(out_index), 0);
    chk("rst_out_value", int'(out_value), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", int'(in_ready), 0);

    // Basic frame
    vals = '{50, 40, 30, 20, 10, 60, 70, 80};
    run_frame(4, 10, 0, 1'b0, 1'b0);

    // Minimum in the last slot, then all-equal frame right after a zero result
    vals = '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 0};
    run_frame(7, 0, 0, 1'b0, 1'b0);
    vals = '{7, 7, 7, 7, 7, 7, 7, 7};
    run_frame(0, 7, 0, 1'b0, 1'b0);
    vals = '{3, 9, 3, 9, 3, 9, 3, 9};
    run_frame(0, 3, 0, 1'b0, 1'b0);

    // Stalls between beats and 3 cycles of backpressure
    vals = '{50, 40, 30, 20, 10, 60, 70, 80};
    gaps = '{0, 1, 3, 2, 1, 3, 2, 1};
    run_frame(4, 10, 3, 1'b0, 1'b0);
    set_no_gaps();

    // Start pulses inside ACCUM and DONE must be ignored
    run_frame(4, 10, 2, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("no_extra_frame_in_ready", int'(in_ready), 0);
    chk("no_extra_frame_busy", int'(busy), 0);

    // Reset after 3 accepted beats
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 10'd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_value", int'(out_value), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_waits_idle", int'(in_ready), 0);
    vals = '{9, 8, 7, 6, 5, 4, 3, 2};
    run_frame(7, 2, 0, 1'b0, 1'b0);

    // Back-to-back: start in the first IDLE cycle after the handshake
    vals = '{100, 1, 100, 100, 100, 100, 100, 100};
    run_frame(1, 1, 0, 1'b0, 1'b0);

    @(posedge clk); #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
